sev_read_decrypt: RTL and testbench

Read-response decryption engine for SEV-style memory encryption. It holds a per-ASID key table and accepts encrypted read-response beats from the memory side. Each beat is decrypted with its VM's key plus an address tweak and delivered to the core side through a 2-stage valid/ready pipeline. It complements the write-side XOR encryptor, and it flags and counts encrypted reads from ASIDs with no valid key.

---
 rtl/sev_read_decrypt.sv | 126 ++++++++++++
 tb/tb_sev_read_decrypt.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sev_read_decrypt.sv
// Read-response decryption engine: per-ASID key table plus a 2-stage valid/ready
// pipeline that XOR-decrypts memory read beats and flags reads from keyless ASIDs.
module sev_read_decrypt #(
  parameter int NUM_ASID = 16,
  parameter int ASID_W   = $clog2(NUM_ASID)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              key_we_i,
  input  logic              key_inv_i,
  input  logic [ASID_W-1:0] key_asid_i,
  input  logic [63:0]       key_i,
  input  logic              rsp_valid_i,
  output logic              rsp_ready_o,
  input  logic [ASID_W-1:0] rsp_asid_i,
  input  logic [63:0]       rsp_addr_i,
  input  logic [63:0]       rsp_data_i,
  input  logic              rsp_enc_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [63:0]       out_data_o,
  output logic              out_fault_o,
  output logic [15:0]       fault_cnt_o
);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Result is {fault, plaintext}; a keyless encrypted beat yields zero data.
  function automatic logic [64:0] decrypt(input logic [63:0] data, input logic enc,
                                          input logic [63:0] key, input logic kv,
                                          input logic [63:0] twk);
    if (!enc)    return {1'b0, data};
    else if (kv) return {1'b0, data ^ key ^ twk};
    else         return {1'b1, 64'h0};
  endfunction

  logic [63:0]         key_q [NUM_ASID];
  logic [NUM_ASID-1:0] kvld_q;

  logic        vld_p1_q, vld_p1_d;
  logic [63:0] data_p1_q, twk_p1_q, key_p1_q;
  logic        enc_p1_q, kv_p1_q;

  logic        vld_p2_q, vld_p2_d;
  logic [63:0] data_p2_q;
  logic        fault_p2_q;
  logic [15:0] cnt_q, cnt_d;

  logic        accept, adv;
  logic [64:0] res_p1;

  assign rsp_ready_o = !vld_p1_q || !vld_p2_q || out_ready_i;
  assign accept      = rsp_valid_i && rsp_ready_o;
  assign adv         = vld_p1_q && (!vld_p2_q || out_ready_i);
  assign res_p1      = decrypt(data_p1_q, enc_p1_q, key_p1_q, kv_p1_q, twk_p1_q);

  always_comb begin
    vld_p1_d = vld_p1_q;
    vld_p2_d = vld_p2_q;
    cnt_d    = cnt_q;
    if (accept)   vld_p1_d = 1'b1;
    else if (adv) vld_p1_d = 1'b0;
    if (adv)              vld_p2_d = 1'b1;
    else if (out_ready_i) vld_p2_d = 1'b0;
    if (adv && res_p1[64]) cnt_d = sat_inc16(cnt_q);
  end

  // Key table: write wins over invalidate; lookups see the pre-edge contents.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_ASID; i++) key_q[i] <= 64'h0;
      kvld_q <= '0;
    end else if (key_we_i) begin
      key_q[key_asid_i]  <= key_i;
      kvld_q[key_asid_i] <= 1'b1;
    end else if (key_inv_i) begin
      kvld_q[key_asid_i] <= 1'b0;
    end
  end

  // Stage 1: capture beat, tweak and looked-up key.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1_q  <= 1'b0;
      data_p1_q <= 64'h0;
      twk_p1_q  <= 64'h0;
      key_p1_q  <= 64'h0;
      enc_p1_q  <= 1'b0;
      kv_p1_q   <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      if (accept) begin
        data_p1_q <= rsp_data_i;
        twk_p1_q  <= rsp_addr_i & ~64'h7;
        key_p1_q  <= key_q[rsp_asid_i];
        enc_p1_q  <= rsp_enc_i;
        kv_p1_q   <= kvld_q[rsp_asid_i];
      end
    end
  end

  // Stage 2: registered decrypted result and fault counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p2_q   <= 1'b0;
      data_p2_q  <= 64'h0;
      fault_p2_q <= 1'b0;
      cnt_q      <= 16'h0;
    end else begin
      vld_p2_q <= vld_p2_d;
      cnt_q    <= cnt_d;
      if (adv) begin
        data_p2_q  <= res_p1[63:0];
        fault_p2_q <= res_p1[64];
      end
    end
  end

  assign out_valid_o = vld_p2_q;
  assign out_data_o  = data_p2_q;
  assign out_fault_o = fault_p2_q;
  assign fault_cnt_o = cnt_q;

endmodule

// File: tb/tb_sev_read_decrypt.sv
// Self-checking bench for sev_read_decrypt: directed scenarios plus randomized
// traffic scored against an in-order queue model of the decryptor.
module tb_sev_read_decrypt;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_we, key_inv;
  logic [3:0]  key_asid;
  logic [63:0] key;
  logic        rsp_valid;
  logic        rsp_ready_o;
  logic [3:0]  rsp_asid;
  logic [63:0] rsp_addr, rsp_data;
  logic        rsp_enc;
  logic        out_valid_o;
  logic        out_ready;
  logic [63:0] out_data_o;
  logic        out_fault_o;
  logic [15:0] fault_cnt_o;

  int n_cmp = 0;
  int n_fail = 0;

  logic [63:0] m_key [16];
  bit          m_val [16];
  logic [63:0] exp_d [$];
  bit          exp_f [$];
  int          fcnt_m;

  always #5 clk = ~clk;

  sev_read_decrypt #(.NUM_ASID(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .key_we_i(key_we), .key_inv_i(key_inv), .key_asid_i(key_asid), .key_i(key),
    .rsp_valid_i(rsp_valid), .rsp_ready_o(rsp_ready_o), .rsp_asid_i(rsp_asid),
    .rsp_addr_i(rsp_addr), .rsp_data_i(rsp_data), .rsp_enc_i(rsp_enc),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready), .out_data_o(out_data_o),
    .out_fault_o(out_fault_o), .fault_cnt_o(fault_cnt_o)
  );

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic int exp_cnt();
    return (fcnt_m > 65535) ? 65535 : fcnt_m;
  endfunction

  task automatic idle_inputs();
    key_we = 0; key_inv = 0; key_asid = 0; key = 0;
    rsp_valid = 0; rsp_asid = 0; rsp_addr = 0; rsp_data = 0; rsp_enc = 0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin m_key[i] = 64'h0; m_val[i] = 0; end
    exp_d.delete(); exp_f.delete(); fcnt_m = 0;
  endtask

  // One clock: check handshake and any delivered beat, update model, advance.
  task automatic cycle(output bit acc);
    bit exp_rdy;
    #1;
    exp_rdy = (exp_d.size() < 2) || out_ready;
    n_cmp++;
    if (rsp_ready_o !== exp_rdy) begin
      n_fail++; $display("FAIL rsp_ready: got %b want %b", rsp_ready_o, exp_rdy);
    end
    if (out_valid_o && out_ready) begin
      n_cmp++;
      if (exp_d.size() == 0) begin
        n_fail++; $display("FAIL unexpected_beat: got data %h, none expected", out_data_o);
      end else begin
        logic [63:0] ed; bit ef;
        ed = exp_d.pop_front(); ef = exp_f.pop_front();
        if (out_data_o !== ed || out_fault_o !== ef) begin
          n_fail++;
          $display("FAIL beat: got %h/%b want %h/%b", out_data_o, out_fault_o, ed, ef);
        end
      end
    end
    acc = rsp_valid && rsp_ready_o;
    if (acc) begin
      if (!rsp_enc) begin
        exp_d.push_back(rsp_data); exp_f.push_back(0);
      end else if (m_val[rsp_asid]) begin
        exp_d.push_back(rsp_data ^ m_key[rsp_asid] ^ (rsp_addr - (rsp_addr % 8)));
        exp_f.push_back(0);
      end else begin
        exp_d.push_back(64'h0); exp_f.push_back(1); fcnt_m++;
      end
    end
    if (key_we) begin m_key[key_asid] = key; m_val[key_asid] = 1; end
    else if (key_inv) m_val[key_asid] = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    bit acc;
    idle_inputs(); out_ready = 1;
    for (int i = 0; i < 10 && exp_d.size() > 0; i++) cycle(acc);
    n_cmp++;
    if (exp_d.size() != 0) begin
      n_fail++; $display("FAIL drain_timeout: got %0d pending want 0", exp_d.size());
    end
    n_cmp++;
    if (fault_cnt_o !== 16'(exp_cnt())) begin
      n_fail++; $display("FAIL fault_cnt: got %0d want %0d", fault_cnt_o, exp_cnt());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    #1;
    n_cmp++;
    if (out_valid_o !== 0 || out_data_o !== 0 || out_fault_o !== 0 ||
        fault_cnt_o !== 0 || rsp_ready_o !== 1) begin
      n_fail++;
      $display("FAIL %s: got v=%b d=%h f=%b c=%0d r=%b want 0/0/0/0/1", tag,
               out_valid_o, out_data_o, out_fault_o, fault_cnt_o, rsp_ready_o);
    end
  endtask

  task automatic test_reset();
    idle_inputs(); out_ready = 0; rst = 1;
    @(negedge clk); @(negedge clk);
    rst = 0; clear_model();
    check_reset_outputs("reset_state");
    @(negedge clk);
  endtask

  task automatic test_key_read();
    bit acc;
    logic [63:0] want;
    want = 64'hFFFF_0000_FFFF_0000 ^ 64'h0123_4567_89AB_CDEF ^ 64'h1008;
    idle_inputs(); out_ready = 1;
    key_we = 1; key_asid = 3; key = 64'h0123_4567_89AB_CDEF;
    cycle(acc);
    idle_inputs();
    rsp_valid = 1; rsp_asid = 3; rsp_addr = 64'h1008; rsp_data = 64'hFFFF_0000_FFFF_0000; rsp_enc = 1;
    cycle(acc);
    idle_inputs();
    #1;
    n_cmp++;
    if (out_valid_o !== 0) begin n_fail++; $display("FAIL latency_s1: got valid %b want 0", out_valid_o); end
    @(posedge clk); @(negedge clk); #1;
    n_cmp++;
    if (out_valid_o !== 1 || out_data_o !== want || out_fault_o !== 0) begin
      n_fail++; $display("FAIL key_read: got %b/%h/%b want 1/%h/0", out_valid_o, out_data_o, out_fault_o, want);
    end
    exp_d.delete(); exp_f.delete();
    @(posedge clk); @(negedge clk);
    drain();
  endtask

  task automatic test_passthrough_fault();
    bit acc;
    idle_inputs(); out_ready = 1;
    rsp_valid = 1; rsp_asid = 1; rsp_addr = 64'h40; rsp_data = 64'hDEAD_BEEF; rsp_enc = 0;
    cycle(acc);
    rsp_asid = 5; rsp_addr = 64'h2000; rsp_data = rand64(); rsp_enc = 1;
    cycle(acc);
    drain();
    n_cmp++;
    if (fault_cnt_o !== 16'd1) begin n_fail++; $display("FAIL fault_cnt_one: got %0d want 1", fault_cnt_o); end
  endtask

  task automatic test_backpressure();
    logic [63:0] b [4];
    logic [63:0] held;
    bit have_held, acc;
    int idx;
    for (int i = 0; i < 4; i++) b[i] = rand64();
    idx = 0; have_held = 0;
    idle_inputs(); out_ready = 0;
    for (int c = 0; c < 5; c++) begin
      rsp_valid = 1; rsp_asid = 3; rsp_enc = 1; rsp_addr = 64'h100 + 64'(8 * idx); rsp_data = b[idx];
      cycle(acc);
      if (acc) idx++;
      #1;
      if (out_valid_o) begin
        if (have_held) begin
          n_cmp++;
          if (out_data_o !== held) begin n_fail++; $display("FAIL hold_stable: got %h want %h", out_data_o, held); end
        end
        held = out_data_o; have_held = 1;
      end
    end
    n_cmp++;
    if (idx != 2) begin n_fail++; $display("FAIL bp_accepts: got %0d want 2", idx); end
    out_ready = 1;
    for (int c = 0; c < 10 && idx < 4; c++) begin
      rsp_valid = 1; rsp_asid = 3; rsp_enc = 1; rsp_addr = 64'h100 + 64'(8 * idx); rsp_data = b[idx];
      cycle(acc);
      if (acc) idx++;
    end
    n_cmp++;
    if (idx != 4) begin n_fail++; $display("FAIL bp_release: got %0d want 4", idx); end
    drain();
  endtask

  task automatic test_same_cycle_write();
    bit acc;
    idle_inputs(); out_ready = 1;
    key_we = 1; key_asid = 2; key = 64'hAAAA_5555_1234_0000;
    cycle(acc);
    idle_inputs();
    key_we = 1; key_asid = 2; key = 64'h0F0F_F0F0_CAFE_BABE;
    rsp_valid = 1; rsp_asid = 2; rsp_enc = 1; rsp_addr = 64'h3010; rsp_data = 64'h1111_2222_3333_4444;
    cycle(acc);
    key_we = 0;
    n_cmp++;
    if (exp_d.size() == 0 || exp_d[exp_d.size()-1] !== (64'h1111_2222_3333_4444 ^ 64'hAAAA_5555_1234_0000 ^ 64'h3010)) begin
      n_fail++; $display("FAIL old_key_model: got accept=%b want old-key beat queued", acc);
    end
    rsp_addr = 64'h3018;
    cycle(acc);
    drain();
  endtask

  task automatic test_invalidate();
    bit acc;
    idle_inputs(); out_ready = 1;
    key_inv = 1; key_asid = 3;
    cycle(acc);
    idle_inputs();
    rsp_valid = 1; rsp_asid = 3; rsp_enc = 1; rsp_addr = 64'h5000; rsp_data = rand64();
    cycle(acc);
    idle_inputs();
    key_we = 1; key_inv = 1; key_asid = 3; key = 64'h7777_8888_9999_AAAA;
    cycle(acc);
    idle_inputs();
    rsp_valid = 1; rsp_asid = 3; rsp_enc = 1; rsp_addr = 64'h500F; rsp_data = 64'h0;
    cycle(acc);
    drain();
  endtask

  task automatic test_random();
    bit acc;
    for (int c = 0; c < 400; c++) begin
      idle_inputs();
      out_ready = ($urandom_range(0, 3) != 0);
      rsp_valid = ($urandom_range(0, 3) != 0);
      rsp_asid = 4'($urandom_range(0, 7));
      rsp_addr = rand64(); rsp_data = rand64(); rsp_enc = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 5) == 0) begin key_we = 1; key_asid = 4'($urandom_range(0, 7)); key = rand64(); end
      if ($urandom_range(0, 7) == 0) begin key_inv = 1; key_asid = 4'($urandom_range(0, 7)); end
      cycle(acc);
    end
    drain();
  endtask

  task automatic test_saturation();
    bit acc;
    int n;
    n = 0;
    idle_inputs(); out_ready = 1;
    for (int c = 0; c < 70000 && n < 65540; c++) begin
      rsp_valid = 1; rsp_asid = 15; rsp_enc = 1; rsp_addr = 64'(c); rsp_data = 64'(c);
      cycle(acc);
      if (acc) n++;
    end
    drain();
    n_cmp++;
    if (fault_cnt_o !== 16'hFFFF) begin n_fail++; $display("FAIL saturate: got %h want ffff", fault_cnt_o); end
  endtask

  task automatic test_mid_reset();
    bit acc;
    idle_inputs(); out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      rsp_valid = 1; rsp_asid = 15; rsp_enc = 1; rsp_data = rand64();
      cycle(acc);
    end
    rst = 1; idle_inputs();
    @(posedge clk); @(negedge clk);
    rst = 0; clear_model();
    check_reset_outputs("mid_reset");
    out_ready = 1;
    for (int c = 0; c < 3; c++) cycle(acc);
    drain();
  endtask

  initial begin
    clear_model();
    test_reset();
    test_key_read();
    test_passthrough_fault();
    test_backpressure();
    test_same_cycle_write();
    test_invalidate();
    test_random();
    test_saturation();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
